// File: rtl/inst_mem_loader_if.sv
// Word stream from the boot/debug program source into the instruction memory loader.
interface inst_mem_loader_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;

  modport master (
    output word_valid,
    output word_data,
    output word_last,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    input  word_last,
    output word_ready
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: takes 32-bit words off a valid/ready stream and writes
// each one as four little-endian bytes through a one-byte-per-cycle write port.
module inst_mem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MEM_BYTES = 65,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  inst_mem_loader_if.slave      s_word,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_waddr,
  output logic [7:0]            o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [5:0]            o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_W0, S_W1, S_W2, S_W3, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [5:0]        r_count;
  logic [31:0]       r_word;
  logic              r_last;
  logic              r_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [5:0]        w_count_nxt;
  logic [31:0]       w_word_nxt;
  logic              w_last_nxt;
  logic [ADDR_W:0]   w_end;
  logic              w_we_nxt;
  logic [1:0]        w_k;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] k);
    case (k)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_word_nxt  = r_word;
    w_last_nxt  = r_last;
    w_end       = '0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          w_state_nxt = S_ACCEPT;
          w_ptr_nxt   = BASE;
          w_count_nxt = '0;
        end
      end
      S_ACCEPT: begin
        if (i_start) begin
          w_ptr_nxt   = BASE;
          w_count_nxt = '0;
        end
        // word_ready is high throughout ACCEPT, so valid alone completes the handshake;
        // a word offered alongside start is taken and written at the base address.
        if (s_word.word_valid) begin
          w_word_nxt  = s_word.word_data;
          w_last_nxt  = s_word.word_last;
          w_end       = {1'b0, w_ptr_nxt} + (ADDR_W+1)'(4);
          w_state_nxt = (w_end > LIMIT) ? S_ERR : S_W0;
        end
      end
      S_W0: w_state_nxt = S_W1;
      S_W1: w_state_nxt = S_W2;
      S_W2: w_state_nxt = S_W3;
      S_W3: begin
        w_ptr_nxt   = r_ptr + ADDR_W'(4);
        w_count_nxt = (r_count == 6'd63) ? r_count : r_count + 6'd1;
        w_state_nxt = r_last ? S_DONE : S_ACCEPT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    w_we_nxt = 1'b0;
    w_k      = 2'd0;
    case (w_state_nxt)
      S_W0: begin w_we_nxt = 1'b1; w_k = 2'd0; end
      S_W1: begin w_we_nxt = 1'b1; w_k = 2'd1; end
      S_W2: begin w_we_nxt = 1'b1; w_k = 2'd2; end
      S_W3: begin w_we_nxt = 1'b1; w_k = 2'd3; end
      default: begin w_we_nxt = 1'b0; w_k = 2'd0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= BASE;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_mem_we <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_count  <= w_count_nxt;
      r_ready  <= (w_state_nxt == S_ACCEPT);
      r_mem_we <= w_we_nxt;
      r_busy   <= (w_state_nxt == S_ACCEPT) || w_we_nxt;
      r_done   <= (w_state_nxt == S_DONE);
      r_error  <= (w_state_nxt == S_ERR);
      if (w_we_nxt) begin
        r_waddr <= w_ptr_nxt + ADDR_W'(w_k);
        r_wdata <= byte_sel(w_word_nxt, w_k);
      end
    end
  end

  // Latched word is pure data and needs no reset.
  always_ff @(posedge clk) begin
    r_word <= w_word_nxt;
    r_last <= w_last_nxt;
  end

  assign s_word.word_ready = r_ready;
  assign o_mem_we          = r_mem_we;
  assign o_mem_waddr       = r_waddr;
  assign o_mem_wdata       = r_wdata;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_word_count      = r_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed, table-driven bench for inst_mem_loader with a byte-memory model.
module tb_inst_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start, start2;

  inst_mem_loader_if bus ();
  inst_mem_loader_if bus2 ();

  logic       mem_we,  mem_we2;
  logic [7:0] mem_waddr, mem_waddr2;
  logic [7:0] mem_wdata, mem_wdata2;
  logic       busy, busy2, done, done2, error, error2;
  logic [5:0] word_count, word_count2;

  inst_mem_loader #(.ADDR_W(8), .MEM_BYTES(65), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .s_word(bus),
    .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
    .o_busy(busy), .o_done(done), .o_error(error), .o_word_count(word_count)
  );

  inst_mem_loader #(.ADDR_W(8), .MEM_BYTES(65), .BASE_ADDR(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .s_word(bus2),
    .o_mem_we(mem_we2), .o_mem_waddr(mem_waddr2), .o_mem_wdata(mem_wdata2),
    .o_busy(busy2), .o_done(done2), .o_error(error2), .o_word_count(word_count2)
  );

  // Byte memory model fed by the write port of the default instance.
  logic [7:0] mem [0:255];
  int         nwr = 0;
  logic       bad_addr = 1'b0;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_waddr >= 8'd65) bad_addr <= 1'b1;
      mem[mem_waddr] <= mem_wdata;
      nwr <= nwr + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where W0 is visible.
  task automatic send_word(input logic [31:0] data, input logic last);
    int n;
    bus.word_data  = data;
    bus.word_last  = last;
    bus.word_valid = 1'b1;
    n = 0;
    while (!bus.word_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_wait", {31'd0, bus.word_ready}, 32'd1);
    @(negedge clk);
    bus.word_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic        do_start;
    int          idle;
    logic [7:0]  addr0;
    logic [7:0]  b0, b1, b2, b3;
    logic [5:0]  cnt;
    logic        done;
  } vec_t;

  vec_t tv [5];

  initial begin
    logic [7:0] eb [4];
    int n0;

    tv[0] = '{word:32'h10000213, last:1'b1, do_start:1'b1, idle:0, addr0:8'd0,
              b0:8'h13, b1:8'h02, b2:8'h00, b3:8'h10, cnt:6'd1, done:1'b1};
    tv[1] = '{word:32'h09000193, last:1'b0, do_start:1'b1, idle:0, addr0:8'd0,
              b0:8'h93, b1:8'h01, b2:8'h00, b3:8'h09, cnt:6'd1, done:1'b0};
    tv[2] = '{word:32'h00418233, last:1'b1, do_start:1'b0, idle:0, addr0:8'd4,
              b0:8'h33, b1:8'h82, b2:8'h41, b3:8'h00, cnt:6'd2, done:1'b1};
    tv[3] = '{word:32'hDEADBEEF, last:1'b0, do_start:1'b1, idle:0, addr0:8'd0,
              b0:8'hEF, b1:8'hBE, b2:8'hAD, b3:8'hDE, cnt:6'd1, done:1'b0};
    tv[4] = '{word:32'h00112233, last:1'b1, do_start:1'b0, idle:3, addr0:8'd4,
              b0:8'h33, b1:8'h22, b2:8'h11, b3:8'h00, cnt:6'd2, done:1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    bus.word_valid = 1'b0;  bus.word_data = '0;  bus.word_last = 1'b0;
    bus2.word_valid = 1'b0; bus2.word_data = '0; bus2.word_last = 1'b0;

    // Reset state and idle hold
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_ready", {31'd0, bus.word_ready}, 32'd0);
    chk("rst_count", {26'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", {31'd0, bus.word_ready}, 32'd0);
    chk("idle_we", {31'd0, mem_we}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    // Table-driven single-word sessions
    for (int i = 0; i < 5; i++) begin
      if (tv[i].do_start) pulse_start();
      for (int j = 0; j < tv[i].idle; j++) begin
        chk("bp_ready", {31'd0, bus.word_ready}, 32'd1);
        chk("bp_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
      end
      send_word(tv[i].word, tv[i].last);
      eb[0] = tv[i].b0; eb[1] = tv[i].b1; eb[2] = tv[i].b2; eb[3] = tv[i].b3;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_we%0d", i, k), {31'd0, mem_we}, 32'd1);
        chk($sformatf("v%0d_addr%0d", i, k), {24'd0, mem_waddr}, {24'd0, tv[i].addr0 + 8'(k)});
        chk($sformatf("v%0d_data%0d", i, k), {24'd0, mem_wdata}, {24'd0, eb[k]});
        chk($sformatf("v%0d_ready%0d", i, k), {31'd0, bus.word_ready}, 32'd0);
        @(negedge clk);
      end
      chk($sformatf("v%0d_count", i), {26'd0, word_count}, {26'd0, tv[i].cnt});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tv[i].done});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, ~tv[i].done});
      chk($sformatf("v%0d_we_after", i), {31'd0, mem_we}, 32'd0);
    end

    // Back-to-back words with word_valid held high
    pulse_start();
    n0 = nwr;
    send_word(32'h09000193, 1'b0);
    bus.word_data  = 32'h00418233;
    bus.word_last  = 1'b1;
    bus.word_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("b2b_ready_low%0d", c), {31'd0, bus.word_ready}, 32'd0);
      @(negedge clk);
    end
    chk("b2b_ready_high", {31'd0, bus.word_ready}, 32'd1);
    @(negedge clk);
    bus.word_valid = 1'b0;
    chk("b2b_w0_addr", {24'd0, mem_waddr}, 32'd4);
    repeat (4) @(negedge clk);
    chk("b2b_nwr", nwr - n0, 32'd8);
    chk("b2b_m0", {24'd0, mem[0]}, 32'h93);
    chk("b2b_m1", {24'd0, mem[1]}, 32'h01);
    chk("b2b_m3", {24'd0, mem[3]}, 32'h09);
    chk("b2b_m4", {24'd0, mem[4]}, 32'h33);
    chk("b2b_m5", {24'd0, mem[5]}, 32'h82);
    chk("b2b_m6", {24'd0, mem[6]}, 32'h41);
    chk("b2b_m7", {24'd0, mem[7]}, 32'h00);
    chk("b2b_count", {26'd0, word_count}, 32'd2);
    chk("b2b_done", {31'd0, done}, 32'd1);

    // Overflow: 16 words fill bytes 0..63, the 17th is refused
    pulse_start();
    for (int w = 0; w < 16; w++) begin
      send_word({4{8'(w)}}, 1'b0);
      repeat (4) @(negedge clk);
    end
    chk("ovf_count16", {26'd0, word_count}, 32'd16);
    chk("ovf_m60", {24'd0, mem[60]}, 32'h0F);
    chk("ovf_m63", {24'd0, mem[63]}, 32'h0F);
    n0 = nwr;
    send_word(32'hCAFEF00D, 1'b0);
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_done", {31'd0, done}, 32'd0);
    chk("ovf_busy", {31'd0, busy}, 32'd0);
    chk("ovf_ready", {31'd0, bus.word_ready}, 32'd0);
    chk("ovf_we", {31'd0, mem_we}, 32'd0);
    repeat (4) @(negedge clk);
    chk("ovf_count_hold", {26'd0, word_count}, 32'd16);
    chk("ovf_error_sticky", {31'd0, error}, 32'd1);
    chk("ovf_no_write", nwr - n0, 32'd0);
    chk("ovf_bad_addr", {31'd0, bad_addr}, 32'd0);
    pulse_start();
    chk("ovf_clear_error", {31'd0, error}, 32'd0);
    chk("ovf_clear_count", {26'd0, word_count}, 32'd0);
    chk("ovf_restart_ready", {31'd0, bus.word_ready}, 32'd1);

    // Reset in W1 of the word at byte 8
    send_word(32'h11111111, 1'b0);
    repeat (4) @(negedge clk);
    send_word(32'h22222222, 1'b0);
    repeat (4) @(negedge clk);
    n0 = nwr;
    send_word(32'h00C0FFEE, 1'b0);
    chk("mid_w0_addr", {24'd0, mem_waddr}, 32'd8);
    @(negedge clk);
    chk("mid_w1_addr", {24'd0, mem_waddr}, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", {31'd0, mem_we}, 32'd0);
    chk("async_addr", {24'd0, mem_waddr}, 32'd0);
    chk("async_data", {24'd0, mem_wdata}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_count", {26'd0, word_count}, 32'd0);
    chk("async_ready", {31'd0, bus.word_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_nwr", nwr - n0, 32'd1);
    chk("mid_m8", {24'd0, mem[8]}, 32'hEE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_we", {31'd0, mem_we}, 32'd0);

    // BASE_ADDR override starts writing at byte 4
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    bus2.word_data  = 32'h10000213;
    bus2.word_last  = 1'b1;
    bus2.word_valid = 1'b1;
    begin
      int n = 0;
      while (!bus2.word_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("base4_ready", {31'd0, bus2.word_ready}, 32'd1);
    @(negedge clk);
    bus2.word_valid = 1'b0;
    chk("base4_we", {31'd0, mem_we2}, 32'd1);
    chk("base4_addr0", {24'd0, mem_waddr2}, 32'd4);
    chk("base4_data0", {24'd0, mem_wdata2}, 32'h13);
    @(negedge clk);
    chk("base4_addr1", {24'd0, mem_waddr2}, 32'd5);
    chk("base4_data1", {24'd0, mem_wdata2}, 32'h02);
    repeat (3) @(negedge clk);
    chk("base4_done", {31'd0, done2}, 32'd1);
    chk("base4_count", {26'd0, word_count2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the byte-addressed instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes each one as four little-endian bytes.
- Byte order matches the fetch read: mem[a] = word[7:0], mem[a+1] = word[15:8], mem[a+2] = word[23:16], mem[a+3] = word[31:24].
- Writes through a one-byte-per-cycle write port.
- Sits between the boot/debug program source and the instruction memory; the processor fetches only after done.

Parameters:
- ADDR_W, 8, byte-address width of the instruction memory.
- MEM_BYTES, 65, number of byte locations (valid byte addresses 0..MEM_BYTES-1).
- BASE_ADDR, 0, byte address of the first instruction written after start.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load session at BASE_ADDR.
- word_valid  input  1  word_data holds a valid instruction.
- word_data  input  32  instruction word.
- word_last  input  1  qualifies word_data as the final word of the session.
- word_ready  output  1  loader can accept a word this cycle.
- mem_we  output  1  byte write enable.
- mem_waddr  output  ADDR_W  byte write address.
- mem_wdata  output  8  byte write data.
- busy  output  1  session active (ACCEPT or WRITE states).
- done  output  1  session completed normally; level.
- error  output  1  overflow occurred; sticky level.
- word_count  output  6  complete words written this session.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low.
  - While rst_n=0, all outputs are 0 immediately and state = IDLE.
  - Internal byte pointer ptr = BASE_ADDR.
  - Any byte write in progress is abandoned with no further mem_we.
- All outputs are registered.
- States: IDLE, ACCEPT, W0, W1, W2, W3, DONE, ERR.
- IDLE/DONE/ERR:
  - start=1 -> ACCEPT.
  - ptr = BASE_ADDR; word_count = 0; done = 0; error = 0.
- ACCEPT:
  - word_ready = 1; busy = 1.
  - Handshake is word_valid & word_ready on a rising edge. On handshake, latch word_data and word_last.
  - If ptr + 4 > MEM_BYTES (sum computed at ADDR_W+1 bits, no wrap): go to ERR. No mem_we; error = 1; ptr and word_count unchanged.
  - Otherwise go to W0.
  - start in ACCEPT restarts: ptr = BASE_ADDR, word_count = 0, stay in ACCEPT.
- W0..W3, one cycle each, word_ready = 0:
  - mem_we = 1, mem_waddr = ptr + k, mem_wdata = byte k of the latched word (k = 0..3).
  - Latency: the first byte write appears in the cycle after the handshake; each word takes 5 cycles (accept + 4 writes).
- Leaving W3:
  - ptr += 4; word_count += 1.
  - Go to DONE if the latched last = 1, else ACCEPT.
  - start is ignored during W0..W3; a word is never partially written except under reset.
- DONE: done = 1, busy = 0, word_ready = 0; word_count holds.
- ERR: error = 1, busy = 0, word_ready = 0; done stays 0.
- word_valid while word_ready = 0 is not consumed; the source holds the word.
- mem_we is 0 in every state except W0..W3; mem_waddr and mem_wdata hold their last values when mem_we = 0.
- Capacity with defaults: 16 words (bytes 0..63). The 17th word (ptr = 64) raises error.
- word_count saturates at 63, which is unreachable with the defaults.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously. Release, then hold IDLE with word_ready=0 and no mem_we.
- Single word: start; send 32'h10000213 with last=1 -> writes (0,13), (1,02), (2,00), (3,10) on cycles 1..4 after the handshake. Then done=1, word_count=1, busy=0.
- Back-to-back words: send 32'h09000193 then 32'h00418233 (last) with word_valid held high -> bytes 93,01,00,09 at 0..3 and 33,82,41,00 at 4..7. word_ready is low for 4 cycles between handshakes; word_count=2.
- Backpressure/idle: drop word_valid for 3 cycles in ACCEPT -> no mem_we, word_ready stays 1, ptr unchanged.
- Overflow: load 16 words without last, then offer a 17th -> no write at byte 64, error=1, done=0, word_count=16. A subsequent start clears error.
- Reset mid-word: rst_n=0 during W1 of a word at ptr 8 -> mem_we drops immediately and only byte 8 was written. After release, start with BASE_ADDR=4 (parameter override) writes the first byte at address 4.
